// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART loopback pair: default sizes, FSM state enums
// and the parity function used by both transmitter and receiver.
package uart_pkg;
  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int PARITY_ODD_DEF = 0;
  localparam int PAR_W          = 32;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START_CHK = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4
  } rx_state_t;

  // Callers zero-extend their payload to PAR_W; extra zeros do not change the XOR.
  function automatic logic calc_parity(input logic [PAR_W-1:0] data, input logic odd);
    calc_parity = (^data) ^ odd;
  endfunction
endpackage

// File: rtl/uart_back_to_back_if.sv
// CPU-side bus of the UART loopback: TX write port and RX read port with status flags.
interface uart_back_to_back_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
);
  logic [DATA_BITS-1:0] tx_d_in;
  logic                 tx_wrn;
  logic                 tx_t_empty;
  logic                 tx_sending;
  logic                 rx_rdn;
  logic [DATA_BITS-1:0] rx_d_out;
  logic                 rx_r_ready;
  logic                 rx_parity_error;
  logic                 rx_frame_error;

  modport master (
    output tx_d_in, tx_wrn, rx_rdn,
    input  tx_t_empty, tx_sending, rx_d_out, rx_r_ready, rx_parity_error, rx_frame_error
  );

  modport slave (
    input  tx_d_in, tx_wrn, rx_rdn,
    output tx_t_empty, tx_sending, rx_d_out, rx_r_ready, rx_parity_error, rx_frame_error
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: start-bit qualification at half a bit, mid-bit sampling of data/parity/stop,
// and a one-deep output register with parity and framing flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = PARITY_ODD_DEF
) (
  input  logic                 clk16x,
  input  logic                 clrn,
  input  logic                 i_line,
  input  logic                 i_rdn,
  output logic [DATA_BITS-1:0] o_d_out,
  output logic                 o_r_ready,
  output logic                 o_parity_error,
  output logic                 o_frame_error
);
  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  rx_state_t            r_state, w_state_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;
  logic [BIT_W-1:0]     r_bit, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_par_bit, w_par_bit_n;
  logic [DATA_BITS-1:0] r_d_out, w_d_out_n;
  logic                 r_ready, w_ready_n;
  logic                 r_perr, w_perr_n;
  logic                 r_ferr, w_ferr_n;
  logic                 r_rdn_d;
  logic                 w_rd_evt;
  logic                 w_bit_end;
  logic                 w_done;

  assign w_rd_evt  = r_rdn_d & ~i_rdn;
  assign w_bit_end = (r_cnt == CNT_LAST);

  // Next-state and capture logic; frame completion takes priority over a read acknowledge.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_bit_n     = r_bit;
    w_shift_n   = r_shift;
    w_par_bit_n = r_par_bit;
    w_d_out_n   = r_d_out;
    w_ready_n   = r_ready;
    w_perr_n    = r_perr;
    w_ferr_n    = r_ferr;
    w_done      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_cnt_n = '0;
        if (!i_line) w_state_n = RX_START_CHK;
        else         w_state_n = RX_IDLE;
      end
      RX_START_CHK: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_n = '0;
          w_bit_n = '0;
          if (!i_line) w_state_n = RX_DATA;
          else         w_state_n = RX_IDLE;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = {i_line, r_shift[DATA_BITS-1:1]};
          if (r_bit == BIT_LAST) w_state_n = RX_PARITY;
          else                   w_bit_n   = r_bit + BIT_W'(1);
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (w_bit_end) begin
          w_cnt_n     = '0;
          w_par_bit_n = i_line;
          w_state_n   = RX_STOP;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_done    = 1'b1;
          w_state_n = RX_IDLE;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = RX_IDLE;
        w_cnt_n   = '0;
      end
    endcase
    if (w_done) begin
      w_d_out_n = r_shift;
      w_ready_n = 1'b1;
      w_perr_n  = (r_par_bit != calc_parity(PAR_W'(r_shift), ODD));
      w_ferr_n  = ~i_line;
    end else if (w_rd_evt) begin
      w_ready_n = 1'b0;
      w_perr_n  = 1'b0;
      w_ferr_n  = 1'b0;
    end else begin
      w_ready_n = r_ready;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk16x) begin
    if (clrn) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_d_out   <= '0;
      r_ready   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_rdn_d   <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit     <= w_bit_n;
      r_shift   <= w_shift_n;
      r_par_bit <= w_par_bit_n;
      r_d_out   <= w_d_out_n;
      r_ready   <= w_ready_n;
      r_perr    <= w_perr_n;
      r_ferr    <= w_ferr_n;
      r_rdn_d   <= i_rdn;
    end
  end

  assign o_d_out        = r_d_out;
  assign o_r_ready      = r_ready;
  assign o_parity_error = r_perr;
  assign o_frame_error  = r_ferr;
endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: one-deep holding buffer feeding a start/data/parity/stop shifter,
// with back-to-back frames when the buffer is refilled before the stop bit ends.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = PARITY_ODD_DEF
) (
  input  logic                 clk16x,
  input  logic                 clrn,
  input  logic [DATA_BITS-1:0] i_d_in,
  input  logic                 i_wrn,
  output logic                 o_t_empty,
  output logic                 o_sending,
  output logic                 o_line
);
  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             ODD      = (PARITY_ODD != 0);

  tx_state_t            r_state, w_state_n;
  logic [CNT_W-1:0]     r_cnt, w_cnt_n;
  logic [BIT_W-1:0]     r_bit, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic [DATA_BITS-1:0] r_buf, w_buf_n;
  logic                 r_par, w_par_n;
  logic                 r_t_empty, w_t_empty_n;
  logic                 r_sending, w_sending_n;
  logic                 r_line, w_line_n;
  logic                 r_wrn_d;
  logic                 w_wr_evt;
  logic                 w_bit_end;
  logic                 w_load;

  assign w_wr_evt  = r_wrn_d & ~i_wrn;
  assign w_bit_end = (r_cnt == CNT_LAST);

  // Next-state and datapath: every bit holds for OVERSAMPLE cycles, then advances.
  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_bit_n     = r_bit;
    w_shift_n   = r_shift;
    w_buf_n     = r_buf;
    w_par_n     = r_par;
    w_t_empty_n = r_t_empty;
    w_sending_n = r_sending;
    w_line_n    = r_line;
    w_load      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!r_t_empty) w_load = 1'b1;
        else            w_load = 1'b0;
      end
      TX_START: begin
        if (w_bit_end) begin
          w_state_n = TX_DATA;
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_line_n  = r_shift[0];
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          w_cnt_n = '0;
          if (r_bit == BIT_LAST) begin
            w_state_n = TX_PARITY;
            w_line_n  = r_par;
          end else begin
            w_bit_n   = r_bit + BIT_W'(1);
            w_shift_n = {1'b0, r_shift[DATA_BITS-1:1]};
            w_line_n  = r_shift[1];
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      TX_PARITY: begin
        if (w_bit_end) begin
          w_state_n = TX_STOP;
          w_cnt_n   = '0;
          w_line_n  = 1'b1;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          w_cnt_n = '0;
          if (!r_t_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_n   = TX_IDLE;
            w_sending_n = 1'b0;
          end
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n   = TX_IDLE;
        w_cnt_n     = '0;
        w_sending_n = 1'b0;
        w_line_n    = 1'b1;
      end
    endcase
    // A load only happens with the buffer full, so it never collides with an accepted write.
    if (w_load) begin
      w_state_n   = TX_START;
      w_shift_n   = r_buf;
      w_par_n     = calc_parity(PAR_W'(r_buf), ODD);
      w_t_empty_n = 1'b1;
      w_sending_n = 1'b1;
      w_line_n    = 1'b0;
      w_cnt_n     = '0;
      w_bit_n     = '0;
    end else if (w_wr_evt && r_t_empty) begin
      w_buf_n     = i_d_in;
      w_t_empty_n = 1'b0;
    end else begin
      w_buf_n = r_buf;
    end
  end

  // State register with synchronous reset that aborts any frame in flight.
  always_ff @(posedge clk16x) begin
    if (clrn) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_buf     <= '0;
      r_par     <= 1'b0;
      r_t_empty <= 1'b1;
      r_sending <= 1'b0;
      r_line    <= 1'b1;
      r_wrn_d   <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit     <= w_bit_n;
      r_shift   <= w_shift_n;
      r_buf     <= w_buf_n;
      r_par     <= w_par_n;
      r_t_empty <= w_t_empty_n;
      r_sending <= w_sending_n;
      r_line    <= w_line_n;
      r_wrn_d   <= i_wrn;
    end
  end

  assign o_t_empty = r_t_empty;
  assign o_sending = r_sending;
  assign o_line    = r_line;
endmodule

// File: rtl/uart_back_to_back.sv
// UART loopback top: transmitter serial output wired straight into the receiver input.
module uart_back_to_back
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = PARITY_ODD_DEF
) (
  input  logic                clk16x,
  input  logic                clrn,
  uart_back_to_back_if.slave  bus
);
  logic w_line;

  uart_tx_core #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_ODD(PARITY_ODD)
  ) u_tx (
    .clk16x   (clk16x),
    .clrn     (clrn),
    .i_d_in   (bus.tx_d_in),
    .i_wrn    (bus.tx_wrn),
    .o_t_empty(bus.tx_t_empty),
    .o_sending(bus.tx_sending),
    .o_line   (w_line)
  );

  uart_rx_core #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_ODD(PARITY_ODD)
  ) u_rx (
    .clk16x        (clk16x),
    .clrn          (clrn),
    .i_line        (w_line),
    .i_rdn         (bus.rx_rdn),
    .o_d_out       (bus.rx_d_out),
    .o_r_ready     (bus.rx_r_ready),
    .o_parity_error(bus.rx_parity_error),
    .o_frame_error (bus.rx_frame_error)
  );
endmodule

// File: tb/tb_uart_back_to_back.sv
// Directed bench for the UART loopback at default parameters (8 data bits, x16, even parity).
module tb_uart_back_to_back;
  logic clk;
  logic clrn;
  int   tests_run;
  int   tests_failed;
  bit   mon_en;
  int   gap_seen;

  uart_back_to_back_if #(.DATA_BITS(8)) bus ();

  uart_back_to_back dut (
    .clk16x(clk),
    .clrn  (clrn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles where the line went idle while a continuous stream was expected.
  always @(negedge clk) begin
    if (mon_en && !bus.tx_sending) gap_seen++;
  end

  task automatic pulse_wr(input logic [7:0] d);
    @(negedge clk);
    bus.tx_d_in = d;
    bus.tx_wrn  = 1'b0;
    @(negedge clk);
    bus.tx_wrn  = 1'b1;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.rx_rdn = 1'b0;
    @(negedge clk);
    bus.rx_rdn = 1'b1;
  endtask

  task automatic wait_ready(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.rx_r_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    bus.tx_wrn = 1'b1;
    bus.rx_rdn = 1'b1;
    bus.tx_d_in = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.tx_t_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_t_empty: got %b want 1", bus.tx_t_empty); end
    tests_run++; if (bus.tx_sending !== 1'b0) begin tests_failed++; $display("FAIL reset_sending: got %b want 0", bus.tx_sending); end
    tests_run++; if (bus.rx_r_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_r_ready: got %b want 0", bus.rx_r_ready); end
    tests_run++; if (bus.rx_d_out !== 8'h00) begin tests_failed++; $display("FAIL reset_d_out: got %h want 00", bus.rx_d_out); end
    tests_run++; if ({bus.rx_parity_error, bus.rx_frame_error} !== 2'b00) begin tests_failed++; $display("FAIL reset_errors: got %b want 00", {bus.rx_parity_error, bus.rx_frame_error}); end
    clrn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    @(negedge clk);
    bus.tx_d_in = 8'hA5;
    bus.tx_wrn  = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.tx_t_empty !== 1'b0) begin tests_failed++; $display("FAIL single_buf_full: got %b want 0", bus.tx_t_empty); end
    bus.tx_wrn = 1'b1;
    @(negedge clk);
    tests_run++; if ({bus.tx_sending, bus.tx_t_empty} !== 2'b11) begin tests_failed++; $display("FAIL single_load: got %b want 11", {bus.tx_sending, bus.tx_t_empty}); end
    wait_ready(180, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_timeout: got %b want 1", ok); end
    tests_run++; if (bus.rx_d_out !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h want a5", bus.rx_d_out); end
    tests_run++; if ({bus.rx_parity_error, bus.rx_frame_error} !== 2'b00) begin tests_failed++; $display("FAIL single_errors: got %b want 00", {bus.rx_parity_error, bus.rx_frame_error}); end
    repeat (10) @(negedge clk);
    tests_run++; if (bus.tx_sending !== 1'b0) begin tests_failed++; $display("FAIL single_sending_end: got %b want 0", bus.tx_sending); end
    pulse_rd();
    @(negedge clk);
    tests_run++; if (bus.rx_r_ready !== 1'b0) begin tests_failed++; $display("FAIL single_read_clear: got %b want 0", bus.rx_r_ready); end
    tests_run++; if (bus.rx_d_out !== 8'hA5) begin tests_failed++; $display("FAIL single_read_hold: got %h want a5", bus.rx_d_out); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] exp_q [3];
    exp_q[0] = 8'hA5; exp_q[1] = 8'h5A; exp_q[2] = 8'h3C;
    gap_seen = 0;
    pulse_wr(8'hA5);
    @(negedge clk);
    mon_en = 1'b1;
    pulse_wr(8'h5A);
    pulse_wr(8'h99);
    tests_run++; if (bus.tx_t_empty !== 1'b0) begin tests_failed++; $display("FAIL b2b_buf_held: got %b want 0", bus.tx_t_empty); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.tx_t_empty) begin ok = 1'b1; break; end
    end
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty_timeout: got %b want 1", ok); end
    pulse_wr(8'h3C);
    for (int k = 0; k < 3; k++) begin
      wait_ready(400, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_timeout_%0d: got %b want 1", k, ok); end
      if (k == 2) mon_en = 1'b0;
      tests_run++; if (bus.rx_d_out !== exp_q[k]) begin tests_failed++; $display("FAIL b2b_data_%0d: got %h want %h", k, bus.rx_d_out, exp_q[k]); end
      pulse_rd();
    end
    mon_en = 1'b0;
    tests_run++; if (gap_seen !== 0) begin tests_failed++; $display("FAIL b2b_idle_gap: got %0d idle cycles want 0", gap_seen); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_parity();
    bit ok;
    logic [7:0] vec [2];
    vec[0] = 8'h01; vec[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      pulse_wr(vec[k]);
      wait_ready(200, ok);
      tests_run++; if ({ok, bus.rx_d_out} !== {1'b1, vec[k]}) begin tests_failed++; $display("FAIL parity_data_%0d: got %b/%h want 1/%h", k, ok, bus.rx_d_out, vec[k]); end
      tests_run++; if (bus.rx_parity_error !== 1'b0) begin tests_failed++; $display("FAIL parity_clean_%0d: got %b want 0", k, bus.rx_parity_error); end
      pulse_rd();
      repeat (10) @(negedge clk);
    end
    // 8'h01 carries even parity bit 1; drive it low during the parity bit window.
    @(negedge clk);
    bus.tx_d_in = 8'h01;
    bus.tx_wrn  = 1'b0;
    @(negedge clk);
    bus.tx_wrn  = 1'b1;
    @(negedge clk);
    repeat (148) @(negedge clk);
    force dut.w_line = 1'b0;
    repeat (8) @(negedge clk);
    release dut.w_line;
    wait_ready(40, ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL parity_bad_ready: got %b want 1", ok); end
    tests_run++; if ({bus.rx_parity_error, bus.rx_frame_error} !== 2'b10) begin tests_failed++; $display("FAIL parity_bad_flags: got %b want 10", {bus.rx_parity_error, bus.rx_frame_error}); end
    tests_run++; if (bus.rx_d_out !== 8'h01) begin tests_failed++; $display("FAIL parity_bad_data: got %h want 01", bus.rx_d_out); end
    pulse_rd();
    @(negedge clk);
    tests_run++; if ({bus.rx_r_ready, bus.rx_parity_error} !== 2'b00) begin tests_failed++; $display("FAIL parity_read_clear: got %b want 00", {bus.rx_r_ready, bus.rx_parity_error}); end
    repeat (20) @(negedge clk);
    // Stop bit window of a frame starting at edge T is T+160..T+176; RX samples at T+169.
    @(negedge clk);
    bus.tx_d_in = 8'h5A;
    bus.tx_wrn  = 1'b0;
    @(negedge clk);
    bus.tx_wrn  = 1'b1;
    @(negedge clk);
    repeat (164) @(negedge clk);
    force dut.w_line = 1'b0;
    repeat (5) @(negedge clk);
    release dut.w_line;
    tests_run++; if ({bus.rx_r_ready, bus.rx_d_out} !== {1'b1, 8'h5A}) begin tests_failed++; $display("FAIL frame_bad_data: got %b/%h want 1/5a", bus.rx_r_ready, bus.rx_d_out); end
    tests_run++; if ({bus.rx_parity_error, bus.rx_frame_error} !== 2'b01) begin tests_failed++; $display("FAIL frame_bad_flags: got %b want 01", {bus.rx_parity_error, bus.rx_frame_error}); end
    pulse_rd();
    repeat (30) @(negedge clk);
  endtask

  task automatic test_overrun();
    bit ok;
    pulse_wr(8'h11);
    pulse_wr(8'h22);
    wait_ready(200, ok);
    tests_run++; if ({ok, bus.rx_d_out} !== {1'b1, 8'h11}) begin tests_failed++; $display("FAIL overrun_first: got %b/%h want 1/11", ok, bus.rx_d_out); end
    repeat (180) @(negedge clk);
    tests_run++; if ({bus.rx_r_ready, bus.rx_d_out} !== {1'b1, 8'h22}) begin tests_failed++; $display("FAIL overrun_second: got %b/%h want 1/22", bus.rx_r_ready, bus.rx_d_out); end
    pulse_rd();
    repeat (10) @(negedge clk);
    // Read strobe lands on the same edge as the next frame's stop sample.
    pulse_wr(8'h33);
    pulse_wr(8'h44);
    wait_ready(200, ok);
    tests_run++; if ({ok, bus.rx_d_out} !== {1'b1, 8'h33}) begin tests_failed++; $display("FAIL collide_first: got %b/%h want 1/33", ok, bus.rx_d_out); end
    repeat (175) @(negedge clk);
    bus.rx_rdn = 1'b0;
    @(negedge clk);
    bus.rx_rdn = 1'b1;
    tests_run++; if ({bus.rx_r_ready, bus.rx_d_out} !== {1'b1, 8'h44}) begin tests_failed++; $display("FAIL collide_completion_wins: got %b/%h want 1/44", bus.rx_r_ready, bus.rx_d_out); end
    pulse_rd();
    @(negedge clk);
    tests_run++; if (bus.rx_r_ready !== 1'b0) begin tests_failed++; $display("FAIL collide_read_after: got %b want 0", bus.rx_r_ready); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    pulse_wr(8'h77);
    repeat (50) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    tests_run++; if ({bus.tx_sending, bus.tx_t_empty, bus.rx_r_ready} !== 3'b010) begin tests_failed++; $display("FAIL midreset_state: got %b want 010", {bus.tx_sending, bus.tx_t_empty, bus.rx_r_ready}); end
    wait_ready(200, ok);
    tests_run++; if (ok !== 1'b0) begin tests_failed++; $display("FAIL midreset_no_phantom: got %b want 0", ok); end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] d;
    for (int n = 0; n < 100; n++) begin
      d = 8'($urandom_range(0, 255));
      pulse_wr(d);
      wait_ready(200, ok);
      tests_run++; if ({ok, bus.rx_d_out} !== {1'b1, d}) begin tests_failed++; $display("FAIL random_%0d: got %b/%h want 1/%h", n, ok, bus.rx_d_out, d); end
      tests_run++; if ({bus.rx_parity_error, bus.rx_frame_error} !== 2'b00) begin tests_failed++; $display("FAIL random_err_%0d: got %b want 00", n, {bus.rx_parity_error, bus.rx_frame_error}); end
      pulse_rd();
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mon_en       = 1'b0;
    gap_seen     = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
